alu_mc: RTL and testbench

Parametrised multi-cycle ALU, successor to the single-cycle combinational ALU in the seq datapath. Adds WIDTH generalisation, valid/ready handshakes on input and output, and iterative unsigned multiply/divide with a high-half result. Sits between decode and writeback; the controller stalls issue while in_ready is low.

---
 rtl/alu_mc.sv | 190 +++++++++++++++++++
 tb/tb_alu_mc.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative unsigned MULU/DIVU.
// Optional macro ALU_OVERFLOW_EN builds the registered signed-overflow flag on 'of'.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_hi,
  output logic             zf,
  output logic             of
);

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_NOR  = 6'd5;
  localparam logic [5:0] OP_SLT  = 6'd6;
  localparam logic [5:0] OP_SLTU = 6'd7;
  localparam logic [5:0] OP_SLL  = 6'd8;
  localparam logic [5:0] OP_SRL  = 6'd9;
  localparam logic [5:0] OP_SRA  = 6'd10;
  localparam logic [5:0] OP_MULU = 6'd16;
  localparam logic [5:0] OP_DIVU = 6'd17;

  localparam int unsigned CNT_W    = SHW + 1;
  localparam logic [SHW:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             zf_q, zf_d;

  logic [WIDTH-1:0] sum, diff, sc_res;
  logic [WIDTH-1:0] iter_lo, iter_hi;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    sc_res = '0;
    case (opcode)
      OP_ADD:  sc_res = sum;
      OP_SUB:  sc_res = diff;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  sc_res = a << b[SHW-1:0];
      OP_SRL:  sc_res = a >> b[SHW-1:0];
      OP_SRA:  sc_res = $signed(a) >>> b[SHW-1:0];
      default: sc_res = '0;
    endcase
  end

  // Working pair {hi_q, lo_q}: multiply shifts right, restoring divide shifts left.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb_q};

  always_comb begin
    iter_lo = lo_q;
    iter_hi = hi_q;
    if (!div_q) begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      iter_hi = div_diff[WIDTH-1:0];
      iter_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      iter_hi = div_sh[WIDTH-1:0];
      iter_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    zf_d    = zf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (opcode == OP_MULU || (opcode == OP_DIVU && b != '0)) begin
            lo_d    = a;
            hi_d    = '0;
            opb_d   = b;
            cnt_d   = '0;
            div_d   = (opcode == OP_DIVU);
            state_d = S_BUSY;
          end else if (opcode == OP_DIVU) begin
            lo_d    = '1;
            hi_d    = a;
            zf_d    = 1'b0;
            state_d = S_DONE;
          end else begin
            lo_d    = sc_res;
            hi_d    = '0;
            zf_d    = (sc_res == '0);
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        lo_d  = iter_lo;
        hi_d  = iter_hi;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          zf_d    = (iter_lo == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      zf_q    <= zf_d;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic of_q, ov_add, ov_sub;

  assign ov_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ov_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      of_q <= 1'b0;
    end else if (state_q == S_IDLE && in_valid) begin
      of_q <= (opcode == OP_ADD && ov_add) || (opcode == OP_SUB && ov_sub);
    end
  end

  assign of = of_q;
`else
  assign of = 1'b0;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign alu_out   = lo_q;
  assign alu_hi    = hi_q;
  assign zf        = zf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (WIDTH=32) with hand-computed expectations.
module tb_alu_mc;

`ifdef ALU_OVERFLOW_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, zf, of;
  logic [31:0] a, b, alu_out, alu_hi;
  logic [5:0]  opcode;

  int errors = 0;
  int checks = 0;

  alu_mc #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .alu_hi(alu_hi), .zf(zf), .of(of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, wait for its result, check it, then hand it off.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input bit exp_of, input int exp_lat);
    int lat;
    bit rdy_seen;
    check({tag, "_rdy_in"}, in_ready, 1'b1);
    in_valid = 1'b1;
    opcode   = op;
    a        = va;
    b        = vb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode   = 6'd2;
    a        = $urandom;
    b        = $urandom;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy_rdy"}, rdy_seen, 1'b0);
    check({tag, "_lo"}, alu_out, exp_lo);
    check({tag, "_hi"}, alu_hi, exp_hi);
    check({tag, "_zf"}, zf, (exp_lo == 32'd0));
    check({tag, "_of"}, of, exp_of);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [14] = '{
    '{6'd2,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000},
    '{6'd3,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF},
    '{6'd4,  32'h0000FFFF, 32'h000000FF, 32'h0000FF00},
    '{6'd5,  32'h00000000, 32'h00000000, 32'hFFFFFFFF},
    '{6'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},
    '{6'd6,  32'h00000001, 32'hFFFFFFFF, 32'h00000000},
    '{6'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},
    '{6'd8,  32'h00000001, 32'h0000001F, 32'h80000000},
    '{6'd8,  32'h00000001, 32'h00000021, 32'h00000002},
    '{6'd9,  32'h80000000, 32'h00000004, 32'h08000000},
    '{6'd10, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF},
    '{6'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},
    '{6'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF},
    '{6'd63, 32'h12345678, 32'h9ABCDEF0, 32'h00000000}
  };

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {in_ready, out_valid, zf, of}, 4'b1000);
    check("rst_data", {alu_out, alu_hi}, 64'd0);
    rst = 1'b0;

    run_op("add", 6'd0, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 1);
    run_op("sub0", 6'd1, 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 1);
    for (int i = 0; i < 14; i++)
      run_op($sformatf("v%0d_op%0d", i, vecs[i].op), vecs[i].op, vecs[i].va, vecs[i].vb,
             vecs[i].lo, 32'd0, 1'b0, 1);
    run_op("unk11", 6'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1);

    run_op("mulu_max", 6'd16, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1, 1'b0, 33);
    run_op("mulu_2p32", 6'd16, 32'h00010000, 32'h00010000, 32'd0, 32'd1, 1'b0, 33);
    run_op("mulu_zero", 6'd16, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33);
    run_op("divu", 6'd17, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run_op("divu_small", 6'd17, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
    run_op("divu_by0", 6'd17, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b0, 1);

    // Backpressure: result held while a new request is presented and ignored.
    in_valid = 1'b1;
    opcode   = 6'd10;
    a        = 32'h80000000;
    b        = 32'd4;
    @(posedge clk);
    #1;
    opcode = 6'd0;
    a      = 32'd1;
    b      = 32'd1;
    check("bp_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", i), {out_valid, in_ready, alu_out}, {2'b10, 32'hF8000000});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_idle", {in_ready, out_valid}, 2'b10);
    @(posedge clk);
    #1;
    check("bp_no_accept", out_valid, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    in_valid = 1'b1;
    opcode   = 6'd16;
    a        = 32'hFFFFFFFF;
    b        = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", {in_ready, out_valid}, 2'b00);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_state", {in_ready, out_valid, zf, of}, 4'b1000);
    check("mid_rst_data", {alu_out, alu_hi}, 64'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle", {in_ready, out_valid}, 2'b10);
    run_op("add_1p1", 6'd0, 32'd1, 32'd1, 32'd2, 32'd0, 1'b0, 1);

    run_op("ovf_add", 6'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 32'd0, OV, 1);
    run_op("ovf_sub", 6'd1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 32'd0, OV, 1);
    run_op("noovf_add", 6'd0, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1);
    run_op("noovf_mulu", 6'd16, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0, 1'b0, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
